// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared pipeline constants, opcodes and register-address type.
// Rev    : 1.0
// ============================================================================
package pipe_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int CNTW = 2;

    localparam logic [2:0] ADD  = 3'b001;
    localparam logic [2:0] SUB  = 3'b010;
    localparam logic [2:0] NAND = 3'b011;
    localparam logic [2:0] NOR  = 3'b100;

    typedef logic [AW-1:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/sb_counter.sv
`default_nettype none
// ============================================================================
// Module : sb_counter
// Brief  : Per-register pending-write up/down counter with saturation flag.
// Rev    : 1.0
// ============================================================================
module sb_counter
    import pipe_pkg::*;
#(
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            dec,
    output logic [CNTW-1:0] count,
    output logic            sat,
    output logic            busy
);

    localparam logic [CNTW-1:0] c_max = '1;
    localparam logic [CNTW-1:0] c_one = CNTW'(1);

    // Simultaneous inc and dec cancel; decrement of an idle counter is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (count != c_max) count <= count + c_one;
        end else if (dec && !inc) begin
            if (count != '0) count <= count - c_one;
        end
    end

    assign sat  = (count == c_max);
    assign busy = (count != '0);

endmodule
`default_nettype wire

// File: rtl/regfile_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : regfile_wb_scoreboard
// Brief  : Register file with pending-write scoreboard; stalls decode on RAW.
//          Optional same-cycle writeback forwarding: define WB_BYPASS_EN.
// Rev    : 1.0
// ============================================================================
module regfile_wb_scoreboard #(
    parameter int NREG = pipe_pkg::NREG,
    parameter int DW   = pipe_pkg::DW,
    parameter int AW   = pipe_pkg::AW,
    parameter int CNTW = pipe_pkg::CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic            issue_wr,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    output logic            stall,
    output logic [DW-1:0]   rdata_a,
    output logic [DW-1:0]   rdata_b,
    output logic            rdata_valid,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [DW-1:0]   wb_data,
    output logic [NREG-1:0] busy_vec,
    output logic            wb_err
);
    import pipe_pkg::*;

    localparam logic [CNTW-1:0] c_one = CNTW'(1);

    logic [DW-1:0]   r_regs [NREG];
    logic [CNTW-1:0] w_pend [NREG];
    logic [NREG-1:0] w_sat;
    logic [NREG-1:0] w_busy;
    logic            w_hz_a;
    logic            w_hz_b;
    logic            w_fwd_a;
    logic            w_fwd_b;
    logic            w_waw;
    logic            w_accept;
    logic [DW-1:0]   w_src_a;
    logic [DW-1:0]   w_src_b;

    assign w_pend[0] = '0;
    assign w_sat[0]  = 1'b0;
    assign w_busy[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        sb_counter #(.CNTW(CNTW)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (w_accept && issue_wr && (issue_rd == AW'(i))),
            .dec   (wb_valid && (wb_rd == AW'(i))),
            .count (w_pend[i]),
            .sat   (w_sat[i]),
            .busy  (w_busy[i])
        );
    end

    always_comb begin
        w_hz_a  = (issue_rs1 != '0) && (w_pend[issue_rs1] != '0);
        w_hz_b  = (issue_rs2 != '0) && (w_pend[issue_rs2] != '0);
        w_fwd_a = 1'b0;
        w_fwd_b = 1'b0;
`ifdef WB_BYPASS_EN
        w_fwd_a = wb_valid && (wb_rd == issue_rs1) && (issue_rs1 != '0);
        w_fwd_b = wb_valid && (wb_rd == issue_rs2) && (issue_rs2 != '0);
        if (w_fwd_a && (w_pend[issue_rs1] == c_one)) w_hz_a = 1'b0;
        if (w_fwd_b && (w_pend[issue_rs2] == c_one)) w_hz_b = 1'b0;
`endif
        // A writeback to the saturated rd frees a slot in the same cycle.
        w_waw    = issue_wr && w_sat[issue_rd] && !(wb_valid && (wb_rd == issue_rd));
        stall    = issue_valid && (w_hz_a || w_hz_b || w_waw);
        w_accept = issue_valid && !stall;
        w_src_a  = w_fwd_a ? wb_data : r_regs[issue_rs1];
        w_src_b  = w_fwd_b ? wb_data : r_regs[issue_rs2];
    end

    // r_regs[0] is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (wb_valid && (wb_rd != '0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a     <= '0;
            rdata_b     <= '0;
            rdata_valid <= 1'b0;
            wb_err      <= 1'b0;
        end else begin
            rdata_valid <= w_accept;
            if (w_accept) begin
                rdata_a <= w_src_a;
                rdata_b <= w_src_b;
            end
            if (wb_valid && (wb_rd != '0) && (w_pend[wb_rd] == '0)) wb_err <= 1'b1;
        end
    end

    assign busy_vec = w_busy;

endmodule
`default_nettype wire
